// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared types for the inter-stage buffers: occupancy encodings, payload field
// layouts for the stage wrappers, and their bubble (NOP) payloads.
package pipeline_stage_buffer_pkg;

  typedef enum logic [1:0] {
    STAGE_OCC_EMPTY = 2'd0,
    STAGE_OCC_HALF  = 2'd1,
    STAGE_OCC_FULL  = 2'd2
  } stage_occ_e;

  // ID/EX payload: {alu_operator, category, operand_a, operand_b, wr_en, wr_addr}
  localparam int ALU_OPERATOR_W = 6;
  localparam int CATEGORY_W     = 3;
  localparam int OPERAND_W      = 32;
  localparam int WR_ADDR_W      = 5;

  localparam int ID_EX_PAYLOAD_W = ALU_OPERATOR_W + CATEGORY_W + 2 * OPERAND_W + 1 + WR_ADDR_W;
  localparam logic [ID_EX_PAYLOAD_W-1:0] ID_EX_NOP = '0;

  // EX/MEM payload: {category, alu_result, store_data, wr_en, wr_addr}
  localparam int EX_MEM_PAYLOAD_W = CATEGORY_W + 2 * OPERAND_W + 1 + WR_ADDR_W;
  localparam logic [EX_MEM_PAYLOAD_W-1:0] EX_MEM_NOP = '0;

  function automatic logic [1:0] occ_count(input stage_occ_e s);
    logic [1:0] n;
    case (s)
      STAGE_OCC_HALF: n = 2'd1;
      STAGE_OCC_FULL: n = 2'd2;
      default:        n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipeline_stage_buffer_if.sv
// Valid/ready stream between two pipeline stages; master drives valid/data,
// slave drives ready.
interface pipeline_stage_buffer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipeline_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the stall monitor and
// any other performance counters that must not wrap.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Two-entry skid buffer between pipeline stages; every output comes from a flop
// so neither ready nor data chains combinationally across stages.
module pipeline_stage_buffer
  import pipeline_stage_buffer_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE       = {DATA_WIDTH{1'b0}},
  parameter int                    STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  pipeline_stage_buffer_if.slave     up,
  pipeline_stage_buffer_if.master    down,
  output logic [STALL_CNT_WIDTH-1:0] stall_count,
  output logic [1:0]                 occupancy
);

  stage_occ_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  down_valid_q;
  logic                  up_ready_q;
  logic [1:0]            occupancy_q;

  logic up_fire;
  logic down_fire;

  assign up_fire   = up.valid & up_ready_q;
  assign down_fire = down_valid_q & down.ready;

  // main_data is reloaded with the bubble whenever the buffer empties, so
  // down_data can be driven straight from the flop.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      STAGE_OCC_EMPTY: begin
        if (up_fire) begin
          state_d     = STAGE_OCC_HALF;
          main_data_d = up.data;
        end
      end
      STAGE_OCC_HALF: begin
        if (up_fire && down_fire) begin
          main_data_d = up.data;
        end else if (up_fire) begin
          state_d     = STAGE_OCC_FULL;
          skid_data_d = up.data;
        end else if (down_fire) begin
          state_d     = STAGE_OCC_EMPTY;
          main_data_d = NOP_VALUE;
        end
      end
      STAGE_OCC_FULL: begin
        if (down_fire) begin
          state_d     = STAGE_OCC_HALF;
          main_data_d = skid_data_q;
        end
      end
      default: begin
        state_d     = STAGE_OCC_EMPTY;
        main_data_d = NOP_VALUE;
      end
    endcase
    if (flush) begin
      state_d     = STAGE_OCC_EMPTY;
      main_data_d = NOP_VALUE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= STAGE_OCC_EMPTY;
      main_data_q  <= NOP_VALUE;
      skid_data_q  <= '0;
      down_valid_q <= 1'b0;
      up_ready_q   <= 1'b1;
      occupancy_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      down_valid_q <= (state_d != STAGE_OCC_EMPTY);
      up_ready_q   <= (state_d != STAGE_OCC_FULL);
      occupancy_q  <= occ_count(state_d);
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (1'b0),
    .enable_i (down_valid_q & ~down.ready),
    .count_o  (stall_count)
  );

  assign up.ready   = up_ready_q;
  assign down.valid = down_valid_q;
  assign down.data  = main_data_q;
  assign occupancy  = occupancy_q;

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Scoreboard bench for pipeline_stage_buffer: accepted beats are queued and
// compared in order as the buffer emits them; a second instance covers saturation.
module tb_pipeline_stage_buffer;

  localparam int         DW  = 8;
  localparam logic [7:0] NOP = 8'hEE;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [15:0] stall_count;
  logic [1:0]  occupancy;
  logic [2:0]  sat_stall;
  logic [1:0]  sat_occ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sb[$];
  logic [15:0] stall_exp;

  pipeline_stage_buffer_if #(.DATA_WIDTH(DW)) up_if ();
  pipeline_stage_buffer_if #(.DATA_WIDTH(DW)) dn_if ();
  pipeline_stage_buffer_if #(.DATA_WIDTH(DW)) sat_up ();
  pipeline_stage_buffer_if #(.DATA_WIDTH(DW)) sat_dn ();

  pipeline_stage_buffer #(
    .DATA_WIDTH      (DW),
    .NOP_VALUE       (NOP),
    .STALL_CNT_WIDTH (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .up          (up_if.slave),
    .down        (dn_if.master),
    .stall_count (stall_count),
    .occupancy   (occupancy)
  );

  pipeline_stage_buffer #(
    .DATA_WIDTH      (DW),
    .NOP_VALUE       (NOP),
    .STALL_CNT_WIDTH (3)
  ) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .flush       (1'b0),
    .up          (sat_up.slave),
    .down        (sat_dn.master),
    .stall_count (sat_stall),
    .occupancy   (sat_occ)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
  endtask

  // Scoreboard update from the handshake seen before the edge, then checks after it.
  task automatic cycle();
    logic       uf, df, stalled;
    logic [7:0] held;
    uf      = (up_if.valid === 1'b1) && (up_if.ready === 1'b1);
    df      = (dn_if.valid === 1'b1) && (dn_if.ready === 1'b1);
    stalled = (dn_if.valid === 1'b1) && (dn_if.ready === 1'b0);
    held    = dn_if.data;
    if (reset) begin
      sb.delete();
      stall_exp = '0;
    end else begin
      if (stalled && stall_exp != 16'hFFFF) stall_exp++;
      if (df) begin
        if (sb.size() == 0) check_val("spurious_valid", 32'(dn_if.valid), 32'd0);
        else                check_val("out_beat", 32'(dn_if.data), 32'(sb.pop_front()));
      end
      if (flush)   sb.delete();
      else if (uf) sb.push_back(up_if.data);
    end
    @(posedge clock);
    #1;
    check_val("occupancy", 32'(occupancy), 32'(sb.size()));
    check_val("down_valid", 32'(dn_if.valid), 32'(sb.size() != 0));
    check_val("up_ready", 32'(up_if.ready), 32'(sb.size() < 2));
    check_val("down_data", 32'(dn_if.data), 32'((sb.size() != 0) ? sb[0] : NOP));
    check_val("stall_count", 32'(stall_count), 32'(stall_exp));
    check_val("legal_state", 32'(!dn_if.valid && !up_if.ready), 32'd0);
    if (stalled && !reset && !flush) check_val("stall_stable", 32'(dn_if.data), 32'(held));
  endtask

  initial begin
    stall_exp    = '0;
    reset        = 1'b1;
    flush        = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    sat_up.valid = 1'b0;
    sat_up.data  = 8'h00;
    sat_dn.ready = 1'b0;

    cycle();
    cycle();
    check_val("rst_down_valid", 32'(dn_if.valid), 32'd0);
    check_val("rst_down_data", 32'(dn_if.data), 32'(NOP));
    check_val("rst_up_ready", 32'(up_if.ready), 32'd1);
    check_val("rst_stall", 32'(stall_count), 32'd0);
    check_val("rst_occ", 32'(occupancy), 32'd0);
    reset = 1'b0;

    // Back-to-back stream with downstream always ready
    drive(1'b1, 8'h11, 1'b1); cycle();
    check_val("lat_11", 32'(dn_if.data), 32'h11);
    drive(1'b1, 8'h22, 1'b1); cycle();
    check_val("lat_22", 32'(dn_if.data), 32'h22);
    drive(1'b1, 8'h33, 1'b1); cycle();
    check_val("lat_33", 32'(dn_if.data), 32'h33);
    check_val("stream_up_ready", 32'(up_if.ready), 32'd1);
    drive(1'b0, 8'h00, 1'b1); cycle();

    // Skid: second beat absorbed while stalled, third refused
    drive(1'b1, 8'hA0, 1'b0); cycle();
    drive(1'b1, 8'hA1, 1'b0); cycle();
    check_val("skid_up_ready", 32'(up_if.ready), 32'd0);
    check_val("skid_occ", 32'(occupancy), 32'd2);
    drive(1'b1, 8'hA2, 1'b0); cycle();
    check_val("skid_hold_a0", 32'(dn_if.data), 32'hA0);
    drive(1'b0, 8'hA2, 1'b1); cycle();
    check_val("skid_out_a1", 32'(dn_if.data), 32'hA1);
    drive(1'b1, 8'hA2, 1'b1); cycle();
    check_val("skid_out_a2", 32'(dn_if.data), 32'hA2);
    drive(1'b0, 8'h00, 1'b1); cycle();

    // Flush while full with a beat on offer
    drive(1'b1, 8'hB0, 1'b0); cycle();
    drive(1'b1, 8'hB1, 1'b0); cycle();
    flush = 1'b1;
    drive(1'b1, 8'hBB, 1'b0); cycle();
    flush = 1'b0;
    check_val("flush_valid", 32'(dn_if.valid), 32'd0);
    check_val("flush_data", 32'(dn_if.data), 32'(NOP));
    check_val("flush_occ", 32'(occupancy), 32'd0);
    check_val("flush_up_ready", 32'(up_if.ready), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) cycle();

    // Stall counter from zero: five stalled cycles
    reset = 1'b1; cycle(); reset = 1'b0;
    drive(1'b1, 8'h5C, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b0);
    repeat (5) cycle();
    check_val("stall_five", 32'(stall_count), 32'd5);

    // Reset while full with a non-zero stall count
    drive(1'b1, 8'hC1, 1'b0); cycle();
    check_val("pre_reset_full", 32'(occupancy), 32'd2);
    check_val("pre_reset_stall_nz", 32'(stall_count != 0), 32'd1);
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b1); cycle();
    reset = 1'b0;
    check_val("midrst_valid", 32'(dn_if.valid), 32'd0);
    check_val("midrst_data", 32'(dn_if.data), 32'(NOP));
    check_val("midrst_up_ready", 32'(up_if.ready), 32'd1);
    check_val("midrst_stall", 32'(stall_count), 32'd0);
    check_val("midrst_occ", 32'(occupancy), 32'd0);
    repeat (3) cycle();

    // Saturation on the 3-bit counter instance
    sat_up.valid = 1'b1;
    sat_up.data  = 8'h77;
    cycle();
    sat_up.valid = 1'b0;
    repeat (5) cycle();
    check_val("sat_mid", 32'(sat_stall), 32'd5);
    repeat (5) cycle();
    check_val("sat_max", 32'(sat_stall), 32'd7);
    check_val("sat_data_held", 32'(sat_dn.data), 32'h77);

    // Random traffic with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 99) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    repeat (4) cycle();
    check_val("drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
Parametrised, generic successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque DATA_WIDTH payload between two pipeline stages under a valid/ready handshake. A two-entry skid buffer keeps every output registered, so neither ready nor data forms a combinational path between stages. It adds flush (branch/exception squash), NOP-bubble insertion, and a saturating stall counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, payload width in bits; the stage concatenates operator/category/operands/write fields into this bus.
NOP_VALUE, {DATA_WIDTH{1'b0}}, payload driven on down_data whenever down_valid is 0 (bubble encoding).
STALL_CNT_WIDTH, 16, width of the stall_count performance counter.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high
flush  input  1  squash all held entries this cycle
up_valid  input  1  upstream stage presents a payload
up_ready  output  1  buffer can accept; registered
up_data  input  DATA_WIDTH  upstream payload
down_valid  output  1  payload available to downstream; registered
down_ready  input  1  downstream accepts this cycle
down_data  output  DATA_WIDTH  payload to downstream; registered
stall_count  output  STALL_CNT_WIDTH  cycles with down_valid=1 and down_ready=0; saturating
occupancy  output  2  entries held (0, 1 or 2)

Behaviour:
- Storage: main entry (main_valid, main_data) drives down_*; skid entry (skid_valid, skid_data) absorbs one beat accepted while downstream stalls.
- States, derived from the valid bits: EMPTY (0,0), HALF (1,0), FULL (1,1). The state (0,1) is illegal.
- up_ready = !skid_valid, taken directly from a flop. down_valid = main_valid. down_data = main_data when main_valid=1, else NOP_VALUE.
- Fire events: up_fire = up_valid & up_ready; down_fire = main_valid & down_ready.
- Transitions for EMPTY:
  - up_fire: HALF, main <= up_data.
- Transitions for HALF:
  - up_fire & down_fire: HALF, main <= up_data.
  - up_fire & !down_fire: FULL, skid <= up_data.
  - !up_fire & down_fire: EMPTY.
- Transitions for FULL (up_ready=0, so no up_fire):
  - down_fire: HALF, main <= skid.
- Latency and throughput:
  - 1 cycle from up_fire to down_valid.
  - 1 beat per cycle sustained when down_ready=1.
  - Order is strictly FIFO.
- flush:
  - Next state is EMPTY and main_data is loaded with NOP_VALUE.
  - Overrides a simultaneous up_fire, so the incoming beat is dropped.
  - A simultaneous down_fire completes; the downstream consumes the current beat.
  - up_ready is 1 in the next cycle.
- reset (priority over flush):
  - main_valid = skid_valid = 0.
  - down_valid = 0, down_data = NOP_VALUE, up_ready = 1.
  - stall_count = 0, occupancy = 0.
  - Reset mid-operation discards both entries.
- stall_count:
  - Increments on each cycle with main_valid & !down_ready.
  - Holds at all-ones.
  - Not cleared by flush.
- occupancy = main_valid + skid_valid, registered.
- Payload is opaque: no arithmetic on data. DATA_WIDTH=1 is legal.
- Assertions for the bench:
  - Never (main_valid=0 & skid_valid=1).
  - While down_valid & !down_ready, down_data is stable.

Decomposition:
- Shared package/defines file (utility): STAGE_OCC_EMPTY/HALF/FULL encodings and the default NOP payload macros per stage.
- Per-stage payload field macros (ALU_OPERATOR_BUS, etc.) remain in the same package; stage wrappers pack and unpack them.
- One natural sub-module: sat_counter (parametrised width, enable, synchronous clear, saturates at max), reused for stall_count and future perf counters.
- Thin wrappers id_ex_stage, ex_mem_stage instantiate pipeline_stage_buffer with their field concatenation.

Test Plan:
- Reset, then stream 0x11,0x22,0x33 with down_ready=1 -> down_data 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept; up_ready stays 1.
- Accept 0xA0, hold down_ready=0, offer 0xA1 and 0xA2 -> 0xA1 goes to skid, up_ready=0, 0xA2 is not accepted, occupancy=2. Release down_ready -> outputs 0xA0, 0xA1, then 0xA2 after re-offer.
- FULL state, assert flush with up_valid=1 (0xBB) -> next cycle down_valid=0, down_data=NOP_VALUE, occupancy=0, up_ready=1, and 0xBB never appears.
- Hold down_valid=1, down_ready=0 for 5 cycles -> stall_count=5. With STALL_CNT_WIDTH=3, stall 10 cycles -> stall_count=7 (saturated).
- Assert reset while FULL and stall_count>0 -> all outputs at reset values next cycle; stored beats never emerge.
- Random valid/ready for 10k cycles against a reference queue -> no loss, no duplication, order preserved, assertions never fire.
